// File: rtl/serial_adder_pkg.sv
// Shared types, limits and helpers for the bit-serial adder.
package serial_adder_pkg;

  // Sequencer states; 2-bit encoding.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Largest supported operand width.
  localparam int unsigned MAX_WIDTH = 32'd32;

  // Bit counter width: enough to count 0..width-1, never narrower than 1 bit.
  function automatic int unsigned cnt_width_f(input int unsigned width);
    if (width <= 32'd1) begin
      return 32'd1;
    end else begin
      return $clog2(width);
    end
  endfunction

endpackage

// File: rtl/fulladder.sv
// The team's existing 1-bit combinational full-adder cell, carried in this
// slice so the serial adder builds stand-alone.
module fulladder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: loads two operands and a carry-in, feeds the full-adder
// cell one bit pair per clock (LSB first), and returns {cout, sum} with a
// one-cycle done pulse.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned    CW       = cnt_width_f(WIDTH);
  localparam logic [CW-1:0]  LAST_CNT = CW'(WIDTH - 32'd1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic             c_q, c_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;

  logic             fa_s;
  logic             fa_cout;
  logic [WIDTH-1:0] acc_shift_s;

  // Per-bit sum and carry come from the shared full-adder cell.
  fulladder u_fa (
    .a   (a_sr_q[0]),
    .b   (b_sr_q[0]),
    .cin (c_q),
    .s   (fa_s),
    .cout(fa_cout)
  );

  // New sum bit enters at the MSB; a 1-bit accumulator is just the sum bit.
  generate
    if (WIDTH == 1) begin : g_acc_w1
      assign acc_shift_s = fa_s;
    end else begin : g_acc_wn
      assign acc_shift_s = {fa_s, acc_q[WIDTH-1:1]};
    end
  endgenerate

  // Next-state, datapath and result update; loads happen from IDLE or DONE.
  always_comb begin
    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    cout_d  = cout_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_sr_d  = a;
          b_sr_d  = b;
          c_d     = cin;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        acc_d  = acc_shift_s;
        a_sr_d = a_sr_q >> 1'b1;
        b_sr_d = b_sr_q >> 1'b1;
        c_d    = fa_cout;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == LAST_CNT) begin
          sum_d   = acc_shift_s;
          cout_d  = fa_cout;
          state_d = DONE;
        end else begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; synchronous reset clears everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule
